// File: rtl/fpu_align_shifter.sv
// Aligns two IEEE-754 singles for the adder: orders by magnitude, right-shifts the smaller mantissa with G/R/S.
// Latency: 2 cycles (unpack/compare/swap, then 5-level sticky barrel shift); 1 transaction per cycle.
// Backpressure: out_ready stalls stage 2, which stalls stage 1; in_ready is combinational from out_ready.
module fpu_align_shifter #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int MANT_W = FRAC_W + 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [EXP_W+FRAC_W:0]    op_a,
    input  logic [EXP_W+FRAC_W:0]    op_b,
    input  logic                     sub,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [MANT_W-1:0]        big_mant,
    output logic [MANT_W-1:0]        small_mant,
    output logic [EXP_W-1:0]         exp_out,
    output logic                     sign_big,
    output logic                     eff_sub,
    output logic                     out_valid,
    input  logic                     out_ready
);
    localparam int DIFF_W = $clog2(MANT_W + 1);

    logic [EXP_W-1:0]  exp_a, exp_b, eexp_a, eexp_b, exp_diff;
    logic [MANT_W-1:0] mant_a, mant_b;
    logic              sign_a, sign_b, a_big;

    logic [MANT_W-1:0] s1_big_d, s1_small_d;
    logic [EXP_W-1:0]  s1_exp_d;
    logic [DIFF_W-1:0] s1_diff_d;
    logic              s1_sign_big_d, s1_eff_sub_d;

    logic              s1_valid_q;
    logic [MANT_W-1:0] s1_big_q, s1_small_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [DIFF_W-1:0] s1_diff_q;
    logic              s1_sign_big_q, s1_eff_sub_q;

    logic [MANT_W-1:0] shift_v, s2_small_d;
    logic              sticky;

    logic              s2_valid_q;
    logic [MANT_W-1:0] s2_big_q, s2_small_q;
    logic [EXP_W-1:0]  s2_exp_q;
    logic              s2_sign_big_q, s2_eff_sub_q;

    logic              s1_load, s2_load;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    // Unpack; denormals use exponent 1 with a clear hidden bit so both operands share one scale.
    always_comb begin
        exp_a  = op_a[FRAC_W +: EXP_W];
        exp_b  = op_b[FRAC_W +: EXP_W];
        eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
        eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
        mant_a = {(exp_a != '0), op_a[FRAC_W-1:0], 3'b000};
        mant_b = {(exp_b != '0), op_b[FRAC_W-1:0], 3'b000};
        sign_a = op_a[EXP_W+FRAC_W];
        sign_b = op_b[EXP_W+FRAC_W] ^ sub;
        a_big  = (eexp_a > eexp_b) || ((eexp_a == eexp_b) && (mant_a >= mant_b));

        s1_big_d      = mant_b;
        s1_small_d    = mant_a;
        s1_exp_d      = eexp_b;
        s1_sign_big_d = sign_b;
        exp_diff      = eexp_b - eexp_a;
        if (a_big) begin
            s1_big_d      = mant_a;
            s1_small_d    = mant_b;
            s1_exp_d      = eexp_a;
            s1_sign_big_d = sign_a;
            exp_diff      = eexp_a - eexp_b;
        end
        s1_eff_sub_d = sign_a ^ sign_b;
        s1_diff_d    = (exp_diff >= EXP_W'(MANT_W)) ? DIFF_W'(MANT_W) : exp_diff[DIFF_W-1:0];
    end

    // Saturated diff of MANT_W shifts everything out, leaving only the sticky bit.
    always_comb begin
        shift_v = s1_small_q;
        sticky  = 1'b0;
        for (int i = 0; i < DIFF_W; i++) begin
            if (s1_diff_q[i]) begin
                sticky  = sticky | (|(shift_v & ((MANT_W'(1) << (1 << i)) - MANT_W'(1))));
                shift_v = shift_v >> (1 << i);
            end
        end
        s2_small_d = {shift_v[MANT_W-1:1], shift_v[0] | sticky};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_big_q      <= '0;
            s1_small_q    <= '0;
            s1_exp_q      <= '0;
            s1_diff_q     <= '0;
            s1_sign_big_q <= 1'b0;
            s1_eff_sub_q  <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_big_q      <= s1_big_d;
                s1_small_q    <= s1_small_d;
                s1_exp_q      <= s1_exp_d;
                s1_diff_q     <= s1_diff_d;
                s1_sign_big_q <= s1_sign_big_d;
                s1_eff_sub_q  <= s1_eff_sub_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            s2_big_q      <= '0;
            s2_small_q    <= '0;
            s2_exp_q      <= '0;
            s2_sign_big_q <= 1'b0;
            s2_eff_sub_q  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_big_q      <= s1_big_q;
                s2_small_q    <= s2_small_d;
                s2_exp_q      <= s1_exp_q;
                s2_sign_big_q <= s1_sign_big_q;
                s2_eff_sub_q  <= s1_eff_sub_q;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign big_mant   = s2_big_q;
    assign small_mant = s2_small_q;
    assign exp_out    = s2_exp_q;
    assign sign_big   = s2_sign_big_q;
    assign eff_sub    = s2_eff_sub_q;

endmodule

// File: tb/tb_fpu_align_shifter.sv
// Randomized and directed bench for fpu_align_shifter against an arithmetic reference model.
module tb_fpu_align_shifter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] op_a, op_b;
    logic        sub, in_valid, in_ready;
    logic [26:0] big_mant, small_mant;
    logic [7:0]  exp_out;
    logic        sign_big, eff_sub, out_valid, out_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_emit   = 0;
    bit          accepted = 1'b0;
    logic [63:0] sb_q[$];

    fpu_align_shifter dut (
        .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready),
        .big_mant(big_mant), .small_mant(small_mant), .exp_out(exp_out),
        .sign_big(sign_big), .eff_sub(eff_sub),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_out();
        return {big_mant, small_mant, exp_out, sign_big, eff_sub};
    endfunction

    // Reference: magnitudes as integers, shift by division, sticky from the remainder.
    function automatic logic [63:0] ref_align(input logic [31:0] a, input logic [31:0] b, input logic s);
        int     ea, eb, ebig, d;
        longint ma, mb, mbig, msm, res, p;
        bit     sa, sbv, sbig, ssm, a_big;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        ma  = ((ea != 0) ? 64'd8388608 : 64'd0) + longint'(a[22:0]);
        mb  = ((eb != 0) ? 64'd8388608 : 64'd0) + longint'(b[22:0]);
        ma  = ma * 8;
        mb  = mb * 8;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        sa  = a[31];
        sbv = b[31] ^ s;
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        if (a_big) begin
            mbig = ma; msm = mb; ebig = ea; d = ea - eb; sbig = sa; ssm = sbv;
        end else begin
            mbig = mb; msm = ma; ebig = eb; d = eb - ea; sbig = sbv; ssm = sa;
        end
        if (d >= 27) begin
            res = (msm != 0) ? 64'd1 : 64'd0;
        end else begin
            p   = 64'd1 << d;
            res = msm / p;
            if (msm % p != 0) res = res | 64'd1;
        end
        return {mbig[26:0], res[26:0], ebig[7:0], sbig, sbig ^ ssm};
    endfunction

    // Inputs are driven at the falling edge; handshakes are sampled just before the rising edge.
    task automatic tick();
        #4;
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_emit++;
            if (sb_q.size() == 0) check_eq("unexpected_out", 64'd1, 64'd0);
            else check_eq("scoreboard", dut_out(), sb_q.pop_front());
        end
        if (accepted) sb_q.push_back(ref_align(op_a, op_b, sub));
        @(negedge clk);
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [63:0] exp_vec);
        out_ready = 1'b1;
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        tick();
        check_eq({tag, "_accept"}, 64'(accepted), 64'd1);
        in_valid = 1'b0;
        check_eq({tag, "_lat1"}, 64'(out_valid), 64'd0);
        tick();
        check_eq({tag, "_lat2"}, 64'(out_valid), 64'd1);
        check_eq(tag, dut_out(), exp_vec);
        tick();
    endtask

    function automatic logic [31:0] rand_pair_b(input logic [31:0] a);
        int ea, eb, mode;
        logic [22:0] fb;
        ea   = int'(a[30:23]);
        mode = $urandom_range(0, 3);
        fb   = 23'($urandom);
        case (mode)
            0: eb = $urandom_range(0, 255);
            1: begin eb = ea; if ($urandom_range(0, 1) == 1) fb = a[22:0]; end
            2: eb = ea - $urandom_range(20, 30);
            default: eb = ea + $urandom_range(0, 3);
        endcase
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
        return {1'($urandom), 8'(eb), fb};
    endfunction

    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    logic [63:0] first_exp;
    int          idx, emit_base;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        #12;
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_outputs", dut_out(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        directed("eq_exp",  32'h3F800000, 32'h3F800000, 1'b0, {27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b0});
        directed("diff1",   32'h3F800000, 32'h40000000, 1'b1, {27'h4000000, 27'h2000000, 8'd128, 1'b1, 1'b1});
        directed("sticky",  32'h4B800000, 32'h3F800001, 1'b0, {27'h4000000, 27'h0000005, 8'd151, 1'b0, 1'b0});
        directed("sat",     32'h7F000000, 32'h3F800000, 1'b0, {27'h4000000, 27'h0000001, 8'd254, 1'b0, 1'b0});
        directed("denorm",  32'h00800000, 32'h00000001, 1'b0, {27'h4000000, 27'h0000008, 8'd1,   1'b0, 1'b0});

        // Backpressure: only two transactions fit while the output is stalled.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = rand_pair_b(bp_a[i]);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            op_a = bp_a[idx]; op_b = bp_b[idx]; sub = 1'b0; in_valid = 1'b1;
            tick();
            if (accepted) idx++;
        end
        check_eq("bp_accepts", 64'(idx), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_out_valid", 64'(out_valid), 64'd1);
        first_exp = ref_align(bp_a[0], bp_b[0], 1'b0);
        check_eq("bp_hold0", dut_out(), first_exp);
        tick();
        check_eq("bp_hold1", dut_out(), first_exp);
        out_ready = 1'b1;
        emit_base = n_emit;
        for (int c = 0; c < 20; c++) begin
            if (idx < 4) begin
                op_a = bp_a[idx]; op_b = bp_b[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (accepted) idx++;
            if (idx == 4 && sb_q.size() == 0) break;
        end
        check_eq("bp_emitted", 64'(n_emit - emit_base), 64'd4);

        // Reset while a result is waiting at the output.
        out_ready = 1'b0;
        op_a = 32'h40400000; op_b = 32'h3F000000; sub = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("rst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_valid", 64'(out_valid), 64'd0);
        check_eq("rst_async_data", dut_out(), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        directed("post_rst", 32'h3F800000, 32'h3F800000, 1'b1, {27'h4000000, 27'h4000000, 8'd127, 1'b0, 1'b1});

        // Random traffic with random stalls; a held transaction keeps its data until accepted.
        in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (!in_valid || accepted) begin
                in_valid = ($urandom_range(0, 9) < 7);
                op_a = $urandom;
                op_b = rand_pair_b(op_a);
                sub  = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (sb_q.size() == 0) break;
            tick();
        end
        check_eq("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
